// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Sequential instruction fetcher for a 16K x 16-bit single-port RAM. A 14-bit
//   program counter walks memory one word at a time through a three-state
//   handshake (IDLE -> REQ -> WAIT). Each fetched word is pushed, tagged with
//   its address, into a small output FIFO. The consumer drains the FIFO with a
//   valid/ready handshake. A redirect (jmp) flushes the FIFO and any word
//   still in flight, then restarts fetching at jmp_addr.
//
// Configuration:
//   FETCH_PREFETCH_EN  defined   -> output FIFO holds 2 entries, so fetching
//                                   continues while the consumer stalls on the
//                                   head. Streaming rate is 1 word / 2 cycles.
//                      undefined -> output FIFO holds 1 entry, and a new fetch
//                                   starts only once the head has been taken.
//                                   Streaming rate is 1 word / 3 cycles.
//   Both builds expose the same interface and deliver words in the same order.
//
// Ports:
//   clk         in   clock; all state updates on the rising edge
//   re          in   synchronous active-high reset; overrides jmp and en
//   en          in   fetch enable
//   jmp         in   redirect request, takes priority over normal fetching
//   jmp_addr    in   [13:0] redirect target word address
//   mem_e       out  RAM enable, high in REQ and WAIT
//   mem_addr    out  [13:0] RAM word address (the current pc)
//   mem_w       out  RAM write strobe, tied to 0
//   mem_r       out  RAM read strobe, high in REQ
//   mem_dout    in   [15:0] RAM read data, valid the cycle after mem_r is sampled
//   inst        out  [15:0] instruction word at the FIFO head
//   inst_pc     out  [13:0] address the head word was read from
//   inst_valid  out  FIFO is non-empty
//   inst_ready  in   consumer takes the head on this edge
// -----------------------------------------------------------------------------
module fetch_unit (
  input  logic        clk,
  input  logic        re,
  input  logic        en,
  input  logic        jmp,
  input  logic [13:0] jmp_addr,
  output logic        mem_e,
  output logic [13:0] mem_addr,
  output logic        mem_w,
  output logic        mem_r,
  input  logic [15:0] mem_dout,
  output logic [15:0] inst,
  output logic [13:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // One pointer bit covers both depths. Storage is sized to the pointer range
  // so every pointer value selects a real entry.
  localparam int PTR_W = 1;
  localparam int SLOTS = 1 << PTR_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] data;
    logic [13:0] pc;
  } entry_t;

  state_e           state_q,  state_d;
  logic [13:0]      pc_q,     pc_d;
  logic             mem_r_q,  mem_r_d;
  logic             mem_e_q,  mem_e_d;
  entry_t           fifo_q [SLOTS];
  entry_t           fifo_d [SLOTS];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             pop;
  logic [CNT_W-1:0] count_after;

  // Advance a FIFO pointer, wrapping at the configured depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pop         = inst_valid & inst_ready;
    count_after = count_q - CNT_W'(pop);

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // count_after is the occupancy once this edge's pop (and, in WAIT, push)
    // have taken effect. A new REQ is only allowed while it is below DEPTH,
    // which reserves a slot for the word that REQ will bring back.
    unique case (state_q)
      IDLE: begin
        if (en && (count_after < CNT_W'(DEPTH))) begin
          state_d = REQ;
        end
      end

      REQ: begin
        state_d = WAIT;
      end

      WAIT: begin
        fifo_d[wr_ptr_q] = '{data: mem_dout, pc: pc_q};
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        count_after      = count_after + CNT_W'(1);
        pc_d             = pc_q + 14'd1;
        state_d          = (en && (count_after < CNT_W'(DEPTH))) ? REQ : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    count_d = count_after;

    // Redirect wins over everything above. A pop on this edge has already
    // been accounted for; resetting the pointers and count then discards
    // whatever is left, including a word being pushed from WAIT.
    if (jmp) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = jmp_addr;
      state_d  = en ? REQ : IDLE;
    end

    // Strobes are registered from the next state so they are glitch-free
    // and line up with the state they describe.
    mem_r_d = (state_d == REQ);
    mem_e_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (re) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      mem_r_q  <= 1'b0;
      mem_e_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the FIFO storage is reset as well because inst and inst_pc are
      // read straight from it and must show 0 after reset; this is only
      // affordable because the storage is a couple of flops, not a RAM.
      for (int i = 0; i < SLOTS; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mem_r_q  <= mem_r_d;
      mem_e_q  <= mem_e_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fifo_q   <= fifo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // pc does not change between REQ and the end of WAIT, so it serves
  // directly as the RAM address.
  assign mem_addr   = pc_q;
  assign mem_r      = mem_r_q;
  assign mem_e      = mem_e_q;
  assign mem_w      = 1'b0;

  // The head only moves on a pop, so it is stable while waiting for ready.
  assign inst       = fifo_q[rd_ptr_q].data;
  assign inst_pc    = fifo_q[rd_ptr_q].pc;
  assign inst_valid = (count_q != '0);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural 16K x 16 RAM answers reads one
// cycle after mem_r is sampled. Inputs are driven 1 time unit after a rising
// edge and outputs are sampled at that same point, away from the edge.
// Build with or without FETCH_PREFETCH_EN to match the RTL build.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH  = 2;
  localparam int PERIOD = 2;
`else
  localparam int DEPTH  = 1;
  localparam int PERIOD = 3;
`endif
  // Whether a word sits in the FIFO when WAIT is first reached with ready=0.
  localparam logic BUF_IN_WAIT = (DEPTH == 2);

  logic        clk;
  logic        re;
  logic        en;
  logic        jmp;
  logic [13:0] jmp_addr;
  logic        mem_e;
  logic [13:0] mem_addr;
  logic        mem_w;
  logic        mem_r;
  logic [15:0] mem_dout;
  logic [15:0] inst;
  logic [13:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  logic [15:0] ram [16384];

  int vectors;
  int miscompares;

  fetch_unit dut (
    .clk        (clk),
    .re         (re),
    .en         (en),
    .jmp        (jmp),
    .jmp_addr   (jmp_addr),
    .mem_e      (mem_e),
    .mem_addr   (mem_addr),
    .mem_w      (mem_w),
    .mem_r      (mem_r),
    .mem_dout   (mem_dout),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model.
  always @(posedge clk) begin
    if (mem_e && mem_r) begin
      mem_dout <= ram[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    re         = 1'b1;
    en         = 1'b0;
    jmp        = 1'b0;
    jmp_addr   = '0;
    inst_ready = 1'b0;
    step(2);
    re         = 1'b0;
  endtask

  // Step until the block shows WAIT (mem_e=1, mem_r=0) with the given
  // inst_valid. The bound expiring counts as a miscompare.
  task automatic wait_for_wait(input logic need_valid, input string name);
    int n;
    n = 0;
    while (!(mem_e === 1'b1 && mem_r === 1'b0 && inst_valid === need_valid) && n < 20) begin
      step(1);
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL %s_reach_wait: WAIT not seen after %0d cycles, required within 20", name, n);
    end
  endtask

  task automatic load_ram();
    for (int i = 0; i < 16384; i++) ram[i] = 16'h0F0F ^ 16'(i);
    ram[0]     = 16'h1111;
    ram[1]     = 16'h2222;
    ram[2]     = 16'h3333;
    ram[3]     = 16'h4444;
    ram[1000]  = 16'hBEEF;
    ram[16383] = 16'hAAAA;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    jmp        = 1'b1;
    jmp_addr   = 14'd77;
    en         = 1'b1;
    inst_ready = 1'b1;
    re         = 1'b1;
    step(2);
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    vectors++; if (mem_r !== 1'b0)      begin miscompares++; $display("FAIL rst_mem_r: got %b want 0", mem_r); end
    vectors++; if (mem_e !== 1'b0)      begin miscompares++; $display("FAIL rst_mem_e: got %b want 0", mem_e); end
    vectors++; if (mem_w !== 1'b0)      begin miscompares++; $display("FAIL rst_mem_w: got %b want 0", mem_w); end
    vectors++; if (mem_addr !== 14'd0)  begin miscompares++; $display("FAIL rst_pc: got %0d want 0", mem_addr); end
    vectors++; if (inst !== 16'h0000)   begin miscompares++; $display("FAIL rst_inst: got %h want 0000", inst); end
    vectors++; if (inst_pc !== 14'd0)   begin miscompares++; $display("FAIL rst_inst_pc: got %0d want 0", inst_pc); end
    do_reset();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fetch();
    logic [15:0] exp_data [4];
    exp_data[0] = 16'h1111;
    exp_data[1] = 16'h2222;
    exp_data[2] = 16'h3333;
    exp_data[3] = 16'h4444;
    do_reset();
    en         = 1'b1;
    inst_ready = 1'b1;
    step(1);  // REQ
    vectors++; if (mem_r !== 1'b1)    begin miscompares++; $display("FAIL fetch_req_mem_r: got %b want 1", mem_r); end
    vectors++; if (mem_e !== 1'b1)    begin miscompares++; $display("FAIL fetch_req_mem_e: got %b want 1", mem_e); end
    vectors++; if (mem_addr !== 14'd0) begin miscompares++; $display("FAIL fetch_req_addr: got %0d want 0", mem_addr); end
    step(1);  // WAIT
    vectors++; if (mem_r !== 1'b0)    begin miscompares++; $display("FAIL fetch_wait_mem_r: got %b want 0", mem_r); end
    vectors++; if (mem_e !== 1'b1)    begin miscompares++; $display("FAIL fetch_wait_mem_e: got %b want 1", mem_e); end
    vectors++; if (mem_addr !== 14'd0) begin miscompares++; $display("FAIL fetch_wait_addr: got %0d want 0", mem_addr); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_wait_valid: got %b want 0", inst_valid); end
    step(1);  // third edge after en: first word
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        step(PERIOD - 1);
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_gap%0d_valid: got %b want 0", k, inst_valid); end
        step(1);
      end
      vectors++; if (inst_valid !== 1'b1)  begin miscompares++; $display("FAIL fetch_w%0d_valid: got %b want 1", k, inst_valid); end
      vectors++; if (inst !== exp_data[k]) begin miscompares++; $display("FAIL fetch_w%0d_inst: got %h want %h", k, inst, exp_data[k]); end
      vectors++; if (inst_pc !== 14'(k))   begin miscompares++; $display("FAIL fetch_w%0d_pc: got %0d want %0d", k, inst_pc, k); end
    end
    vectors++; if (mem_w !== 1'b0) begin miscompares++; $display("FAIL fetch_mem_w: got %b want 0", mem_w); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    int popped;
    do_reset();
    en         = 1'b1;
    inst_ready = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      step(1);
      if (e >= 3) begin
        vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL bp_e%0d_valid: got %b want 1", e, inst_valid); end
        vectors++; if (inst !== 16'h1111)   begin miscompares++; $display("FAIL bp_e%0d_inst: got %h want 1111", e, inst); end
        vectors++; if (inst_pc !== 14'd0)   begin miscompares++; $display("FAIL bp_e%0d_pc: got %0d want 0", e, inst_pc); end
      end
      if (e >= 6) begin
        vectors++; if (mem_r !== 1'b0) begin miscompares++; $display("FAIL bp_e%0d_mem_r: got %b want 0", e, mem_r); end
      end
    end
    // Drain with fetching stopped and count what was buffered.
    en         = 1'b0;
    inst_ready = 1'b1;
    popped     = 0;
    for (int c = 0; c < 6; c++) begin
      if (inst_valid === 1'b1 && popped < 4) begin
        vectors++; if (inst !== ram[popped])      begin miscompares++; $display("FAIL bp_pop%0d_inst: got %h want %h", popped, inst, ram[popped]); end
        vectors++; if (inst_pc !== 14'(popped))   begin miscompares++; $display("FAIL bp_pop%0d_pc: got %0d want %0d", popped, inst_pc, popped); end
        popped++;
      end
      step(1);
    end
    vectors++; if (popped !== DEPTH) begin miscompares++; $display("FAIL bp_buffered: got %0d words want %0d", popped, DEPTH); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_jump();
    do_reset();
    en         = 1'b1;
    inst_ready = 1'b0;
    wait_for_wait(BUF_IN_WAIT, "jmp");
    jmp      = 1'b1;
    jmp_addr = 14'd1000;
    step(1);
    jmp      = 1'b0;
    inst_ready = 1'b1;
    vectors++; if (inst_valid !== 1'b0)   begin miscompares++; $display("FAIL jmp_flush_valid: got %b want 0", inst_valid); end
    vectors++; if (mem_r !== 1'b1)        begin miscompares++; $display("FAIL jmp_req_mem_r: got %b want 1", mem_r); end
    vectors++; if (mem_addr !== 14'd1000) begin miscompares++; $display("FAIL jmp_req_addr: got %0d want 1000", mem_addr); end
    step(1);
    vectors++; if (inst_valid !== 1'b0)   begin miscompares++; $display("FAIL jmp_drop_valid: got %b want 0", inst_valid); end
    step(1);
    vectors++; if (inst_valid !== 1'b1)   begin miscompares++; $display("FAIL jmp_target_valid: got %b want 1", inst_valid); end
    vectors++; if (inst !== 16'hBEEF)     begin miscompares++; $display("FAIL jmp_target_inst: got %h want beef", inst); end
    vectors++; if (inst_pc !== 14'd1000)  begin miscompares++; $display("FAIL jmp_target_pc: got %0d want 1000", inst_pc); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    do_reset();
    en         = 1'b1;
    inst_ready = 1'b0;
    wait_for_wait(BUF_IN_WAIT, "rstmid");
    re = 1'b1;
    step(1);
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", inst_valid); end
    vectors++; if (mem_r !== 1'b0)      begin miscompares++; $display("FAIL rstmid_mem_r: got %b want 0", mem_r); end
    vectors++; if (mem_e !== 1'b0)      begin miscompares++; $display("FAIL rstmid_mem_e: got %b want 0", mem_e); end
    vectors++; if (mem_addr !== 14'd0)  begin miscompares++; $display("FAIL rstmid_pc: got %0d want 0", mem_addr); end
    vectors++; if (inst !== 16'h0000)   begin miscompares++; $display("FAIL rstmid_inst: got %h want 0000", inst); end
    re         = 1'b0;
    inst_ready = 1'b1;
    step(1);
    vectors++; if (mem_r !== 1'b1)      begin miscompares++; $display("FAIL rstmid_restart_mem_r: got %b want 1", mem_r); end
    vectors++; if (mem_addr !== 14'd0)  begin miscompares++; $display("FAIL rstmid_restart_addr: got %0d want 0", mem_addr); end
    step(2);
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_w0_valid: got %b want 1", inst_valid); end
    vectors++; if (inst !== 16'h1111)   begin miscompares++; $display("FAIL rstmid_w0_inst: got %h want 1111", inst); end
    vectors++; if (inst_pc !== 14'd0)   begin miscompares++; $display("FAIL rstmid_w0_pc: got %0d want 0", inst_pc); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_en_drop();
    do_reset();
    en         = 1'b1;
    inst_ready = 1'b1;
    wait_for_wait(1'b0, "endrop");
    en = 1'b0;
    step(1);
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL endrop_valid: got %b want 1", inst_valid); end
    vectors++; if (inst !== 16'h1111)   begin miscompares++; $display("FAIL endrop_inst: got %h want 1111", inst); end
    vectors++; if (inst_pc !== 14'd0)   begin miscompares++; $display("FAIL endrop_pc: got %0d want 0", inst_pc); end
    for (int c = 0; c < 5; c++) begin
      vectors++; if (mem_r !== 1'b0) begin miscompares++; $display("FAIL endrop_idle%0d_mem_r: got %b want 0", c, mem_r); end
      step(1);
    end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL endrop_drained: got %b want 0", inst_valid); end
    en = 1'b1;
    step(1);
    vectors++; if (mem_r !== 1'b1)      begin miscompares++; $display("FAIL endrop_resume_mem_r: got %b want 1", mem_r); end
    vectors++; if (mem_addr !== 14'd1)  begin miscompares++; $display("FAIL endrop_resume_addr: got %0d want 1", mem_addr); end
    step(2);
    vectors++; if (inst !== 16'h2222)   begin miscompares++; $display("FAIL endrop_w1_inst: got %h want 2222", inst); end
    vectors++; if (inst_pc !== 14'd1)   begin miscompares++; $display("FAIL endrop_w1_pc: got %0d want 1", inst_pc); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    ram[0] = 16'h5555;
    do_reset();
    en         = 1'b1;
    inst_ready = 1'b1;
    jmp        = 1'b1;
    jmp_addr   = 14'd16383;
    step(1);
    jmp = 1'b0;
    vectors++; if (mem_addr !== 14'd16383) begin miscompares++; $display("FAIL wrap_req_addr: got %0d want 16383", mem_addr); end
    step(2);
    vectors++; if (inst_valid !== 1'b1)    begin miscompares++; $display("FAIL wrap_w0_valid: got %b want 1", inst_valid); end
    vectors++; if (inst !== 16'hAAAA)      begin miscompares++; $display("FAIL wrap_w0_inst: got %h want aaaa", inst); end
    vectors++; if (inst_pc !== 14'd16383)  begin miscompares++; $display("FAIL wrap_w0_pc: got %0d want 16383", inst_pc); end
    vectors++; if (mem_addr !== 14'd0)     begin miscompares++; $display("FAIL wrap_pc_next: got %0d want 0", mem_addr); end
    step(PERIOD);
    vectors++; if (inst_valid !== 1'b1)    begin miscompares++; $display("FAIL wrap_w1_valid: got %b want 1", inst_valid); end
    vectors++; if (inst !== 16'h5555)      begin miscompares++; $display("FAIL wrap_w1_inst: got %h want 5555", inst); end
    vectors++; if (inst_pc !== 14'd0)      begin miscompares++; $display("FAIL wrap_w1_pc: got %0d want 0", inst_pc); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    re          = 1'b0;
    en          = 1'b0;
    jmp         = 1'b0;
    jmp_addr    = '0;
    inst_ready  = 1'b0;
    load_ram();
    #1;

    test_reset();
    test_fetch();
    test_backpressure();
    test_jump();
    test_reset_mid();
    test_en_drop();
    test_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
